// File: rtl/esc_pwm_driver.sv
// esc_pwm_driver: four frame-aligned servo PWM channels with per-frame double-buffered widths
// and an arm sequencer that sends minimum-width frames before it follows the commanded speeds.
module esc_pwm_driver #(
    parameter int PERIOD_W   = 20,
    parameter int MIN_PULSE  = 6250,
    parameter int SPD_MULT   = 3,
    parameter int ARM_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [10:0] frnt_spd,
    input  logic [10:0] bck_spd,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    output logic        frnt,
    output logic        bck,
    output logic        lft,
    output logic        rght,
    output logic        frm_strt,
    output logic        armed
);
    localparam int CW = PERIOD_W > 16 ? PERIOD_W : 16;

    typedef enum logic [1:0] {DISARM, ARMING, RUN} state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [3:0]          arm_cnt_q, arm_cnt_d;
    logic [15:0]         wid_q [4];
    logic [15:0]         wid_d [4];
    logic [3:0]          pwm_q, pwm_d;
    logic                frm_strt_q, frm_strt_d;
    logic [10:0]         spd [4];
    logic                frm_end;

    always_comb begin
        spd        = '{frnt_spd, bck_spd, lft_spd, rght_spd};
        cnt_d      = cnt_q + PERIOD_W'(1);
        frm_end    = &cnt_q;
        frm_strt_d = frm_end;
        state_d    = state_q;
        arm_cnt_d  = arm_cnt_q;
        // Disarm takes priority over any frame-boundary transition.
        if (!en) begin
            state_d   = DISARM;
            arm_cnt_d = '0;
        end else if (frm_end) begin
            if (state_q == DISARM) begin
                state_d   = ARMING;
                arm_cnt_d = '0;
            end else if (state_q == ARMING) begin
                state_d   = arm_cnt_q == 4'(ARM_FRAMES - 1) ? RUN : ARMING;
                arm_cnt_d = arm_cnt_q == 4'(ARM_FRAMES - 1) ? '0 : arm_cnt_q + 4'd1;
            end
        end
        // Widths and outputs look one cycle ahead so the registered pulse rises at cnt==0.
        for (int i = 0; i < 4; i++) begin
            wid_d[i] = !frm_end ? wid_q[i] :
                       state_d == RUN ? 16'(MIN_PULSE) + 16'(SPD_MULT) * {5'b0, spd[i]} :
                       16'(MIN_PULSE);
            pwm_d[i] = state_d != DISARM && CW'(cnt_d) < CW'(wid_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            state_q    <= DISARM;
            arm_cnt_q  <= '0;
            wid_q      <= '{default: 16'(MIN_PULSE)};
            pwm_q      <= '0;
            frm_strt_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            arm_cnt_q  <= arm_cnt_d;
            wid_q      <= wid_d;
            pwm_q      <= pwm_d;
            frm_strt_q <= frm_strt_d;
        end
    end

    assign {rght, lft, bck, frnt} = pwm_q;
    assign frm_strt               = frm_strt_q;
    assign armed                  = state_q == RUN;
endmodule
